// File: rtl/rns_sequencer.sv
// rns_sequencer: walks a run of RNS moduli. For each modulus it reads its
// parameters from an external table, restarts the RNS datapath with that
// configuration and waits for completion, with timeout and abort handling.
module rns_sequencer #(
   parameter int LOGI    = 4,
   parameter int M       = 17,
   parameter int SCALEW  = 12,
   parameter int TIMEOUT = 8320
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [LOGI:0]     num_moduli,
   input  logic [SCALEW-1:0] scale,
   output logic [LOGI-1:0]   param_rd_addr,
   input  logic [3+M:0]      param_rd_data,
   output logic              rns_rst,
   output logic [LOGI-1:0]   rns_modulus_select,
   output logic [SCALEW-1:0] rns_scale,
   output logic [3:0]        rns_current_k,
   output logic [M-1:0]      rns_qm,
   input  logic              rns_done,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              modulus_done,
   output logic [LOGI-1:0]   cur_modulus
);

   // Counter is shared by ARM (2 cycles) and RUN (up to TIMEOUT cycles).
   localparam int              CW       = (TIMEOUT < 2) ? 2 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [LOGI:0]   MAX_N    = {1'b1, {LOGI{1'b0}}};
   localparam logic [LOGI:0]   IDX_ONE  = {{LOGI{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ARM,
      S_RUN,
      S_NEXT,
      S_FINISH
   } state_t;

   state_t            state_reg, state_next;
   logic [LOGI:0]     idx_reg, idx_next;
   logic [LOGI:0]     nm_reg, nm_next;
   logic [SCALEW-1:0] scale_reg, scale_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic              err_reg, err_next;
   logic [LOGI-1:0]   sel_reg, sel_next;
   logic [SCALEW-1:0] rscale_reg, rscale_next;
   logic [3:0]        k_reg, k_next;
   logic [M-1:0]      qm_reg, qm_next;

   // State and datapath-configuration registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         idx_reg    <= '0;
         nm_reg     <= '0;
         scale_reg  <= '0;
         cnt_reg    <= '0;
         err_reg    <= 1'b0;
         sel_reg    <= '0;
         rscale_reg <= '0;
         k_reg      <= '0;
         qm_reg     <= '0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         nm_reg     <= nm_next;
         scale_reg  <= scale_next;
         cnt_reg    <= cnt_next;
         err_reg    <= err_next;
         sel_reg    <= sel_next;
         rscale_reg <= rscale_next;
         k_reg      <= k_next;
         qm_reg     <= qm_next;
      end
   end

   // Next-state logic; abort takes priority over everything in an active run.
   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      nm_next     = nm_reg;
      scale_next  = scale_reg;
      cnt_next    = cnt_reg;
      err_next    = err_reg;
      sel_next    = sel_reg;
      rscale_next = rscale_reg;
      k_next      = k_reg;
      qm_next     = qm_reg;

      if (abort && state_reg != S_IDLE && state_reg != S_FINISH) begin
         err_next   = 1'b1;
         state_next = S_FINISH;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  if (num_moduli != '0 && num_moduli <= MAX_N) begin
                     nm_next    = num_moduli;
                     scale_next = scale;
                     err_next   = 1'b0;
                     idx_next   = '0;
                     state_next = S_FETCH;
                  end else begin
                     err_next   = 1'b1;
                     state_next = S_FINISH;
                  end
               end
            end
            S_FETCH: begin
               state_next = S_LATCH;
            end
            S_LATCH: begin
               k_next      = param_rd_data[3+M:M];
               qm_next     = param_rd_data[M-1:0];
               sel_next    = idx_reg[LOGI-1:0];
               rscale_next = scale_reg;
               cnt_next    = '0;
               state_next  = S_ARM;
            end
            S_ARM: begin
               if (cnt_reg == CNT_ONE) begin
                  cnt_next   = '0;
                  state_next = S_RUN;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            S_RUN: begin
               // The first RUN cycle (count 0) never honours rns_done.
               if (cnt_reg != '0 && rns_done) begin
                  state_next = S_NEXT;
               end else if (cnt_reg == CNT_LAST) begin
                  err_next   = 1'b1;
                  state_next = S_FINISH;
               end else begin
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
            S_NEXT: begin
               if (idx_reg == nm_reg - IDX_ONE) begin
                  state_next = S_FINISH;
               end else begin
                  idx_next   = idx_reg + IDX_ONE;
                  state_next = S_FETCH;
               end
            end
            S_FINISH: begin
               state_next = S_IDLE;
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
      end
   end

   // Status and strobes decode directly from the state register.
   always_comb begin
      busy         = (state_reg != S_IDLE);
      done         = (state_reg == S_FINISH);
      modulus_done = (state_reg == S_NEXT);
      rns_rst      = (state_reg == S_ARM);
   end

   assign err                = err_reg;
   assign cur_modulus        = idx_reg[LOGI-1:0];
   assign param_rd_addr      = idx_reg[LOGI-1:0];
   assign rns_modulus_select = sel_reg;
   assign rns_scale          = rscale_reg;
   assign rns_current_k      = k_reg;
   assign rns_qm             = qm_reg;

endmodule

// File: doc/rns_sequencer.md
RNS_SEQUENCER -- requirements
Module: rns_sequencer

Interface
REQ-001 Parameter LOGI, default 4: modulus-index width; up to 2^LOGI moduli per run.
REQ-002 Parameter M, default 17: non-zero-bit field width of a modulus (qm).
REQ-003 Parameter SCALEW, default 12: width of scale (exponent bits + 1).
REQ-004 Parameter TIMEOUT, default 8320: maximum RUN cycles per modulus before an error is raised.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request; accepted only in IDLE.
REQ-008 abort  in  1  terminates an active run.
REQ-009 num_moduli  in  LOGI+1  number of moduli to process; legal range 1..2^LOGI; sampled with start.
REQ-010 scale  in  SCALEW  scale exponent; sampled with start.
REQ-011 param_rd_addr  out  LOGI  address of the per-modulus parameter table.
REQ-012 param_rd_data  in  4+M  {current_k[3:0], qm[M-1:0]}; valid 1 cycle after the address.
REQ-013 rns_rst  out  1  active-high restart strobe to the RNS datapath.
REQ-014 rns_modulus_select  out  LOGI  modulus index to the datapath.
REQ-015 rns_scale  out  SCALEW; rns_current_k  out  4; rns_qm  out  M: datapath configuration.
REQ-016 rns_done  in  1  datapath completion level; cleared while rns_rst is high.
REQ-017 busy  out  1; done  out  1 (one-cycle pulse); err  out  1 (sticky); modulus_done  out  1 (one-cycle pulse); cur_modulus  out  LOGI.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, LATCH, ARM, RUN, NEXT and FINISH.
REQ-019 In IDLE, start with num_moduli in 1..2^LOGI SHALL latch num_moduli and scale, clear err, set idx=0, and go to FETCH.
REQ-020 In IDLE, start with num_moduli=0 or >2^LOGI SHALL set err and go to FINISH without asserting rns_rst.
REQ-021 FETCH SHALL drive param_rd_addr=idx for 1 cycle and then go to LATCH.
REQ-022 LATCH SHALL register param_rd_data into rns_current_k/rns_qm and set rns_modulus_select=idx, then go to ARM.
REQ-023 ARM SHALL hold rns_rst=1 for exactly 2 cycles with all rns_* configuration outputs stable, then go to RUN.
REQ-024 rns_* configuration outputs SHALL remain constant from LATCH until the next LATCH or IDLE.
REQ-025 RUN SHALL ignore rns_done in its first cycle and SHALL leave on rns_done=1 on any later cycle, going to NEXT.
REQ-026 RUN SHALL count cycles; when the count reaches TIMEOUT without rns_done, the block SHALL set err and go to FINISH.
REQ-027 NEXT SHALL pulse modulus_done for 1 cycle.
REQ-028 From NEXT, if idx==num_moduli-1 the block SHALL go to FINISH; otherwise it SHALL set idx=idx+1 and go to FETCH.
REQ-029 idx arithmetic SHALL be LOGI+1 bits wide so that num_moduli=2^LOGI terminates without wrap; cur_modulus=idx[LOGI-1:0].
REQ-030 FINISH SHALL pulse done for 1 cycle and return to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 abort in any non-IDLE state except FINISH SHALL set err and go to FINISH next cycle; abort wins over rns_done and timeout in the same cycle.
REQ-033 abort in IDLE SHALL be ignored.
REQ-034 start while busy SHALL be ignored and SHALL NOT change latched num_moduli or scale.
REQ-035 rns_rst SHALL be 0 outside ARM.
REQ-036 Minimum overhead per modulus, excluding RUN, SHALL be 5 cycles (FETCH 1, LATCH 1, ARM 2, NEXT 1).

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE with busy, done, err, modulus_done and rns_rst at 0.
REQ-038 rst_n=0 SHALL asynchronously force idx, cur_modulus, param_rd_addr, rns_modulus_select, rns_scale, rns_current_k, rns_qm and the RUN counter to 0.
REQ-039 Reset asserted mid-run SHALL abandon the run without a done pulse; the first start after reset release SHALL be accepted.

Verification
REQ-040 start, num_moduli=3, scale=5, datapath model raising rns_done 8200 cycles after rns_rst falls -> rns_rst seen 3 times with modulus_select 0,1,2, three modulus_done pulses, one done pulse, err=0.
REQ-041 Parameter table entries {k=6,qm=0x1ABCD}, {k=7,qm=0x00011} -> rns_current_k/rns_qm match each entry throughout the corresponding ARM and RUN states.
REQ-042 num_moduli=0 -> done pulses 1 cycle after start, err=1, rns_rst never asserted.
REQ-043 rns_done held 0 -> err=1 and done pulse after TIMEOUT RUN cycles; second run with a well-behaved model -> err cleared on start.
REQ-044 abort during modulus 1 of 4 in the same cycle as rns_done -> no modulus_done for modulus 1, FINISH next, err=1.
REQ-045 num_moduli=16 -> idx reaches 15, exactly 16 modulus_done pulses; rst_n pulsed low during RUN -> all outputs 0 immediately, no done pulse.
